// File: rtl/zbus_cycle.sv
// zbus_cycle: Z80 control-bus cycle classifier and strober.
//
// Samples the raw Z80 control lines on each zpos tick and classifies every
// bus cycle into a 3-bit type code. It also emits one-clk start/end strobes,
// measures cycle length in zpos ticks (saturating) and flags cycles that
// stay active too long.
//
// Optional feature macro: ZBUS_WAIT_EN. When defined, IO and INTACK cycles
// hold wait_n low for IO_WAITS zpos ticks. When undefined, wait_n is held 1.
//
// Ports:
//   clk, rst        FPGA clock, asynchronous active-high reset
//   zpos            one-clk enable marking the Z80 clock rising-edge sample
//   iorq_n, mreq_n, m1_n, rfsh_n, rd_n, wr_n   raw Z80 control (active low)
//   cyc_type        0 NONE,1 OPFETCH,2 MEMRD,3 MEMWR,4 IORD,5 IOWR,6 INTACK,7 RFSH
//   cyc_act         cycle in progress
//   cyc_start       one-clk strobe, cyc_type valid in the same clk
//   cyc_end         one-clk strobe, cyc_len valid in the same clk
//   cyc_len         number of zpos samples the finished cycle was active
//   cyc_tmo         timeout flag, sticky until cyc_end
//   wait_n          Z80 WAIT request (active low)
module zbus_cycle #(
    parameter int CNT_W    = 8,
    parameter int TMO_LEN  = 0,
    parameter int RFSH_EN  = 0,
    parameter int IO_WAITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             zpos,
    input  logic             iorq_n,
    input  logic             mreq_n,
    input  logic             m1_n,
    input  logic             rfsh_n,
    input  logic             rd_n,
    input  logic             wr_n,
    output logic [2:0]       cyc_type,
    output logic             cyc_act,
    output logic             cyc_start,
    output logic             cyc_end,
    output logic [CNT_W-1:0] cyc_len,
    output logic             cyc_tmo,
    output logic             wait_n
);

    typedef enum logic [1:0] {IDLE, ACTIVE, WAITST} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nx;
    logic             s_io, s_mem, s_m1, s_rf, s_rd, s_wr, s_new;
    logic [2:0]       k, pk;
    logic             any, rise, fall, primed, primed_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc, len_nx;
    logic [2:0]       cls, type_nx;
    logic             start_nx, end_nx, tmo_nx, do_start;

    // Refresh requests are masked out of req_mem unless they are reported.
    logic mem_d;
    assign mem_d = !mreq_n && (rfsh_n || (RFSH_EN != 0));

    // Request kinds: a change of kind with no idle sample in between
    // (fetch -> refresh, mreq -> iorq) is treated as end + start.
    assign k    = {s_io, s_mem & s_rf, s_mem & ~s_rf};
    assign any  = |k;
    assign rise = |(k & ~pk);
    assign fall = |(pk & ~k);

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign cyc_act = (state != IDLE);

    always_comb begin
        cls = 3'd5;
        if (s_io && s_m1)                cls = 3'd6;
        else if (s_mem && s_rf)          cls = 3'd7;
        else if (s_mem && s_m1 && s_rd)  cls = 3'd1;
        else if (s_mem && s_rd)          cls = 3'd2;
        else if (s_mem)                  cls = 3'd3;
        else if (s_io && s_rd)           cls = 3'd4;
    end

`ifdef ZBUS_WAIT_EN
    logic       wait_r, wait_nx;
    logic [3:0] wcnt, wcnt_nx;
    assign wait_n = wait_r;
`else
    assign wait_n = 1'b1;
`endif

    always_comb begin
        state_nx  = state;
        primed_nx = primed;
        cnt_nx    = cnt;
        type_nx   = cyc_type;
        len_nx    = cyc_len;
        tmo_nx    = cyc_tmo;
        start_nx  = 1'b0;
        end_nx    = 1'b0;
        do_start  = 1'b0;
`ifdef ZBUS_WAIT_EN
        wait_nx   = wait_r;
        wcnt_nx   = wcnt;
`endif
        // s_new marks the clk after a zpos sample, so all events land
        // exactly one clk after the sample that shows them.
        if (s_new) begin
            if (!primed) begin
                // Ignore a cycle already in flight at reset release.
                if (!any) primed_nx = 1'b1;
            end else if (state == IDLE) begin
                do_start = rise;
            end else if (rise || fall) begin
                end_nx   = 1'b1;
                len_nx   = cnt;
                tmo_nx   = 1'b0;
                do_start = any;
                if (!any) state_nx = IDLE;
`ifdef ZBUS_WAIT_EN
                wait_nx  = 1'b1;
`endif
            end else begin
                cnt_nx = cnt_inc;
                if ((TMO_LEN != 0) && (32'(cnt_inc) == TMO_LEN)) tmo_nx = 1'b1;
            end
        end

        if (do_start) begin
            state_nx = ACTIVE;
            start_nx = 1'b1;
            cnt_nx   = 1;
            type_nx  = cls;
            tmo_nx   = (TMO_LEN == 1);
`ifdef ZBUS_WAIT_EN
            if ((IO_WAITS > 0) && (cls == 3'd4 || cls == 3'd5 || cls == 3'd6)) begin
                state_nx = WAITST;
                wcnt_nx  = 4'(IO_WAITS);
            end
`endif
        end

`ifdef ZBUS_WAIT_EN
        // wait_n drops the clk after cyc_start; only zpos ticks that see it
        // low are counted.
        if (state == WAITST && !end_nx && !start_nx) begin
            if (wait_r) begin
                wait_nx = 1'b0;
            end else if (zpos) begin
                wcnt_nx = wcnt - 1'b1;
                if (wcnt == 4'd1) begin
                    wait_nx  = 1'b1;
                    state_nx = ACTIVE;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            {s_io, s_mem, s_m1, s_rf, s_rd, s_wr} <= '0;
            s_new     <= 1'b0;
            pk        <= '0;
            primed    <= 1'b0;
            cnt       <= '0;
            cyc_type  <= '0;
            cyc_len   <= '0;
            cyc_tmo   <= 1'b0;
            cyc_start <= 1'b0;
            cyc_end   <= 1'b0;
`ifdef ZBUS_WAIT_EN
            wait_r    <= 1'b1;
            wcnt      <= '0;
`endif
        end else begin
            if (zpos) begin
                s_io  <= !iorq_n;
                s_mem <= mem_d;
                s_m1  <= !m1_n;
                s_rf  <= !rfsh_n;
                s_rd  <= !rd_n;
                s_wr  <= !wr_n;
            end
            s_new     <= zpos;
            pk        <= k;
            state     <= state_nx;
            primed    <= primed_nx;
            cnt       <= cnt_nx;
            cyc_type  <= type_nx;
            cyc_len   <= len_nx;
            cyc_tmo   <= tmo_nx;
            cyc_start <= start_nx;
            cyc_end   <= end_nx;
`ifdef ZBUS_WAIT_EN
            wait_r    <= wait_nx;
            wcnt      <= wcnt_nx;
`endif
        end
    end

    // wr is sampled for completeness; MEMWR/IOWR are the default classes.
    logic unused_sig;
`ifdef ZBUS_WAIT_EN
    assign unused_sig = s_wr;
`else
    assign unused_sig = s_wr ^ (IO_WAITS > 0);
`endif

endmodule

// File: doc/zbus_cycle.md
Name: zbus_cycle

Overview:
- Parametrised successor to the Z80 signal decoder/strober.
- Samples the raw Z80 control bus on zpos and classifies each bus cycle into a single type code.
- Emits one-clk start/end strobes, measures cycle length in Z80 clocks, and flags over-long cycles.
- Sits between the Z80 pin interface and the memory/port arbiters; optionally generates IO wait states.

Parameters:
CNT_W, 8, width of cycle-length counter (saturating)
TMO_LEN, 0, zpos ticks after which an active cycle raises cyc_tmo; 0 disables timeout
RFSH_EN, 0, 1: refresh cycles reported as type RFSH; 0: refresh ignored
IO_WAITS, 1, Z80 clocks of wait_n low per IO cycle (used only with ZBUS_WAIT_EN; legal 0..15)

Ports:
clk  in  1  FPGA clock
rst  in  1  asynchronous active-high reset
zpos  in  1  one-clk enable, Z80 clock rising-edge sample point
iorq_n, mreq_n, m1_n, rfsh_n, rd_n, wr_n  in  1 each  raw Z80 control
cyc_type  out  3  type of current/last cycle: 0 NONE, 1 OPFETCH, 2 MEMRD, 3 MEMWR, 4 IORD, 5 IOWR, 6 INTACK, 7 RFSH
cyc_act  out  1  cycle in progress
cyc_start  out  1  one-clk strobe, cyc_type valid same clk
cyc_end  out  1  one-clk strobe, cyc_len valid same clk
cyc_len  out  CNT_W  zpos samples the finished cycle was active
cyc_tmo  out  1  timeout flag, sticky until cyc_end
wait_n  out  1  Z80 WAIT request, active low

Behaviour:
- Reset: all outputs 0 except wait_n=1. FSM in IDLE, sample registers 0, primed=0.
- Sampling: on clk with zpos=1, register the decoded request:
  - req_io = !iorq_n
  - req_mem = !mreq_n && (rfsh_n || RFSH_EN)
  - m1, rd, wr, rfsh are sampled alongside.
- Edge detect: a second stage updates every clk, so strobes appear exactly one clk after the zpos sample showing the change.
- Classification at start, in priority order:
  - iorq && m1 -> INTACK
  - mreq && !rfsh_n -> RFSH
  - mreq && m1 && rd -> OPFETCH
  - mreq && rd -> MEMRD
  - mreq -> MEMWR
  - iorq && rd -> IORD
  - iorq -> IOWR
- Classification is latched for the whole cycle; later changes of rd/wr do not alter cyc_type.
- cyc_type holds its value after cyc_end until the next cyc_start.
- FSM:
  - IDLE -> ACTIVE on rising sampled request (req_io||req_mem); cyc_start=1, cyc_act=1, counter=1.
  - ACTIVE: counter +1 per zpos, saturates at 2^CNT_W-1. When counter reaches TMO_LEN (TMO_LEN!=0), set cyc_tmo.
  - ACTIVE -> IDLE on falling sampled request; cyc_end=1, cyc_len=counter, cyc_act=0, cyc_tmo cleared in the same clk.
  - ACTIVE -> WAIT (feature only) on IORD/IOWR/INTACK start when IO_WAITS>0.
- Simultaneous end and start: one request drops while another rises in the same sample (mreq -> iorq). Both cyc_end (old length) and cyc_start (new type) pulse in the same clk; FSM stays ACTIVE, counter restarts at 1.
- Back-to-back same-kind request with no idle sample is one cycle.
- Reset release mid-cycle: primed=0 until a sample with no request. Cycles already active at release produce no strobes and no counting. primed=1 thereafter.
- rst asserted mid-cycle: immediate return to reset values; no cyc_end emitted.
- zpos low: no sampling and no counting; strobes are never wider than one clk.

Optional Feature:
ZBUS_WAIT_EN defined:
- WAIT state implemented.
- wait_n is driven 0 from the clk after cyc_start of IORD/IOWR/INTACK for IO_WAITS zpos ticks, then returns to 1 and the FSM returns to ACTIVE.
- Wait ticks are included in cyc_len.
- If the request falls during WAIT (protocol violation), wait_n is released immediately and the cycle ends normally.
- Memory cycles are never waited.

ZBUS_WAIT_EN undefined:
- No WAIT state; wait_n constant 1.
- IO_WAITS ignored.

Test Plan:
- Opcode fetch: m1_n, mreq_n, rd_n low for 2 zpos samples, then refresh with RFSH_EN=0 -> cyc_start with type 1, then cyc_end with cyc_len=2; no second cycle reported.
- Memory write (mreq_n low 3 samples, wr_n low from 2nd sample) -> type 3, cyc_len=3. With RFSH_EN=1, the refresh following a fetch -> separate type 7 cycle.
- IO read 4 samples with ZBUS_WAIT_EN, IO_WAITS=2 -> type 4, wait_n low for exactly 2 zpos ticks starting one clk after cyc_start, cyc_len=4. Without the macro, wait_n stays 1.
- INTACK (iorq_n and m1_n low together) -> type 6, not type 4.
- mreq_n high and iorq_n low in the same sample -> cyc_end and cyc_start in the same clk, new type IORD.
- TMO_LEN=5, mreq held 8 samples -> cyc_tmo rises on the 5th sample and clears with cyc_end (cyc_len=8). CNT_W=3 with 10 samples -> cyc_len=7 (saturated).
- rst pulsed while mreq is active -> outputs cleared, no strobes until mreq deasserts; the next fetch is reported normally.
